// File: rtl/button_enable_ctrl.sv
// -----------------------------------------------------------------------------
// button_enable_ctrl
//
// Debounces the raw active-low push-button and converts it into the `enable`
// level for the downstream LED blink controller. A short (debounced) press
// toggles enable; holding the button past LONG_PRESS_CYCLES forces enable low.
//
// Ports:
//   i_clk        system clock, single domain
//   i_rst        synchronous active-high reset
//   i_btn_n      raw push-button, asynchronous, 0 = pressed
//   o_btn_level  debounced button state, 1 = pressed
//   o_press      one-cycle pulse per accepted press
//   o_long_press one-cycle pulse when a press reaches LONG_PRESS_CYCLES
//   o_enable     level output to the blink controller
// -----------------------------------------------------------------------------
module button_enable_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_btn_level,
  output logic o_press,
  output logic o_long_press,
  output logic o_enable
);

  localparam int unsigned CntW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] LpMax  = CntW'(LONG_PRESS_CYCLES);
  localparam logic [CntW-1:0] LpLast = CntW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } state_e;

  logic [1:0]      r_sync;
  logic            w_raw_p;
  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_long_done, w_long_done_d;
  logic            r_press, w_press_d;
  logic            r_long_press, w_long_press_d;
  logic            r_enable, w_enable_d;
  logic            r_btn_level, w_btn_level_d;

  // Synchroniser flops reset to "released" so raw_p comes out of reset as 0.
  assign w_raw_p = ~r_sync[1];

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_long_done_d  = r_long_done;
    w_press_d      = 1'b0;
    w_long_press_d = 1'b0;
    w_enable_d     = r_enable;

    unique case (r_state)
      StIdle: begin
        w_long_done_d = 1'b0;
        if (w_raw_p) begin
          w_state_d = StPressWait;
          w_cnt_d   = CntW'(1);
        end else begin
          w_cnt_d = '0;
        end
      end

      StPressWait: begin
        if (!w_raw_p) begin
          // Glitch: drop back without any pulse or toggle.
          w_state_d     = StIdle;
          w_cnt_d       = '0;
          w_long_done_d = 1'b0;
        end else if (r_cnt == DbLast) begin
          w_state_d  = StPressed;
          w_cnt_d    = '0;
          w_press_d  = 1'b1;
          w_enable_d = ~r_enable;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      StPressed: begin
        if (!w_raw_p) begin
          w_state_d = StReleaseWait;
          w_cnt_d   = CntW'(1);
        end else if (r_cnt != LpMax) begin
          w_cnt_d = r_cnt + CntW'(1);
          if (r_cnt == LpLast) begin
            w_long_press_d = 1'b1;
            w_enable_d     = 1'b0;
            w_long_done_d  = 1'b1;
          end
        end
      end

      StReleaseWait: begin
        if (w_raw_p) begin
          // Release bounce: resume the press. A saturated counter keeps
          // long_press from firing twice within one press.
          w_state_d = StPressed;
          w_cnt_d   = r_long_done ? LpMax : '0;
        end else if (r_cnt == DbLast) begin
          w_state_d     = StIdle;
          w_cnt_d       = '0;
          w_long_done_d = 1'b0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase

    // Registered from next state so the level rises together with press.
    w_btn_level_d = (w_state_d == StPressed) || (w_state_d == StReleaseWait);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync       <= 2'b11;
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_long_done  <= 1'b0;
      r_press      <= 1'b0;
      r_long_press <= 1'b0;
      r_enable     <= 1'b0;
      r_btn_level  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_btn_n};
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_long_done  <= w_long_done_d;
      r_press      <= w_press_d;
      r_long_press <= w_long_press_d;
      r_enable     <= w_enable_d;
      r_btn_level  <= w_btn_level_d;
    end
  end

  assign o_btn_level  = r_btn_level;
  assign o_press      = r_press;
  assign o_long_press = r_long_press;
  assign o_enable     = r_enable;

endmodule

// File: doc/button_enable_ctrl.md
# button_enable_ctrl

Debounces the board's raw push-button and turns it into the `enable` level that drives the LED blink controller directly downstream. The raw input is synchronised into `clk`, qualified by a stable-time counter, and run through a four-state press/release FSM. Each accepted short press toggles `enable`. A press held past a long-press threshold forces `enable` low.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz); must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 50000000: cycles in PRESSED before `long_press` fires (1 s at 50 MHz); must be > `DEBOUNCE_CYCLES`.

Ports:
- `clk`  input  1  system clock (50 MHz); one clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `btn_n`  input  1  raw push-button, asynchronous, active-low (0 = pressed).
- `btn_level`  output  1  debounced button state, 1 = pressed.
- `press`  output  1  one-cycle pulse on each accepted press.
- `long_press`  output  1  one-cycle pulse when a press reaches `LONG_PRESS_CYCLES`.
- `enable`  output  1  level output to the blink controller's `enable`.

## Operation

- **Synchroniser:** two flops on `btn_n`, then inversion, give `raw_p` (1 = pressed). Both flops reset to 1, so `raw_p` resets to 0.
- **Counter:** one counter, width `$clog2(LONG_PRESS_CYCLES+1)`, shared by all states. It saturates and never wraps.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE with counter 0.
- **IDLE:**
  - `raw_p`=1 → PRESS_WAIT, counter=1.
  - Otherwise stay, counter=0.
- **PRESS_WAIT:**
  - `raw_p`=0 → IDLE, counter=0. This is a glitch; there is no pulse and no toggle.
  - `raw_p`=1 and counter = `DEBOUNCE_CYCLES`-1 → PRESSED, counter=0.
  - Otherwise counter+1.
- **PRESSED:**
  - `raw_p`=0 → RELEASE_WAIT, counter=1.
  - Otherwise counter+1, saturating at `LONG_PRESS_CYCLES`.
  - The edge where the counter goes `LONG_PRESS_CYCLES`-1 → `LONG_PRESS_CYCLES` asserts `long_press`. It fires at most once per press.
- **RELEASE_WAIT:**
  - `raw_p`=1 → PRESSED. The counter is restored to its saturated/long value, so `long_press` cannot fire a second time within the same press, and no new `press` pulse is issued.
  - `raw_p`=0 and counter = `DEBOUNCE_CYCLES`-1 → IDLE, counter=0.
  - Otherwise counter+1.
- **Long-press flag:** a sticky `long_done` bit restores the counter value in RELEASE_WAIT → PRESSED. It is cleared on entry to IDLE.
- **`btn_level`:** 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- **`enable`:**
  - Toggles on the edge that enters PRESSED from PRESS_WAIT.
  - Is forced to 0 on the edge that asserts `long_press`.
  - Long press wins over everything else. A toggle and a long press can never coincide.

## Timing

- **Reset values:** `btn_level`=0, `press`=0, `long_press`=0, `enable`=0. Reset mid-press returns to IDLE. If the button is still held after reset, it must be re-qualified through PRESS_WAIT, which produces a fresh `press` and toggle.
- **Registered outputs:** all outputs come from flops; there is no combinational path from `btn_n`.
- **Press latency:** from the first `clk` edge sampling `btn_n`=0 to `press`=1 is 2 (synchroniser) + `DEBOUNCE_CYCLES` cycles, provided the input is held stable.
- **Same-cycle updates:** `press`, the `enable` toggle and `btn_level` rising all become visible in the same cycle.
- **`long_press`:** asserted in the cycle the counter reaches `LONG_PRESS_CYCLES`, which is `LONG_PRESS_CYCLES` cycles after `press`. `enable` reads 0 in that same cycle.
- **Release latency:** `btn_level` falls 2 + `DEBOUNCE_CYCLES` cycles after a stable release.
- **Minimum press spacing:** one full press/release cycle is at least 2·`DEBOUNCE_CYCLES` cycles.
- **Pulse widths:** `press` and `long_press` are each exactly 1 cycle wide.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=16.

1. **Reset check:** hold `rst`=1 for 3 cycles with `btn_n`=0 → all outputs 0. After `rst` falls, `press` fires on cycle 6 and `enable`=1.
2. **Bounce rejection:** `btn_n` low for 3 cycles then high → no `press`, `btn_level`=0, `enable` unchanged.
3. **Clean press toggles:** two clean presses (low 8, high 8) → `press` pulses once per press. `enable` goes 0→1→0 and `btn_level` tracks each press with a 6-cycle delay.
4. **Release bounce:** hold low for 10 cycles, bounce high 2 cycles, low 3, then high → one `press`, no second pulse, and `btn_level` stays 1 through the bounce.
5. **Long press:** hold low for 30 cycles after `enable`=1 → `press` toggles `enable` to 0. Then `long_press` fires once 16 cycles after `press`, `enable` stays 0, and there is no second pulse. Repeat from `enable`=0 to show `enable` is forced to 0 at `long_press`.
6. **Reset while pressed:** assert `rst` while in PRESSED with `enable`=1 → the next cycle shows all outputs 0. The still-held button is re-accepted after 6 cycles and `enable`=1.
